// File: rtl/nibble_scan_ctrl.sv
// Range scanner in front of the 32:1 nibble mux: steps the mux select over an
// inclusive, wrapping index range and streams {index, nibble} with a running sum.
module nibble_scan_ctrl #(
  parameter int SEL_W  = 5,
  parameter int DATA_W = 4,
  parameter int SUM_W  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [SEL_W-1:0]  first,
  input  logic [SEL_W-1:0]  last,
  output logic [SEL_W-1:0]  sel,
  input  logic [DATA_W-1:0] mux_y,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SEL_W-1:0]  out_idx,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done,
  output logic [SUM_W-1:0]  sum
);

  // state | meaning
  // IDLE  | waiting for start; outputs quiet
  // RUN   | stepping sel, capturing mux_y into the output register
  // DRAIN | last entry captured, waiting for the consumer to take it
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [SEL_W-1:0] SEL_ONE = {{(SEL_W-1){1'b0}}, 1'b1};

  state_t           state;
  logic [SEL_W-1:0] end_idx;
  logic             capture;

  // The output register is free when empty or being drained this cycle.
  assign capture = !out_valid || out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      sel       <= '0;
      end_idx   <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_data  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sum       <= '0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state     <= IDLE;
        out_valid <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state   <= RUN;
              sel     <= first;
              end_idx <= last;
              sum     <= '0;
              busy    <= 1'b1;
            end
          end
          RUN: begin
            if (capture) begin
              out_data  <= mux_y;
              out_idx   <= sel;
              out_valid <= 1'b1;
              sum       <= sum + SUM_W'(mux_y);
              if (sel == end_idx) begin
                state <= DRAIN;
              end else begin
                sel <= sel + SEL_ONE;
              end
            end
          end
          DRAIN: begin
            if (out_valid && out_ready) begin
              out_valid <= 1'b0;
              done      <= 1'b1;
              busy      <= 1'b0;
              state     <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
